chip_74109_emulator: RTL and testbench
======================================

Name: chip_74109_emulator

Overview:
- Behavioural stand-in for a 74109 dual JK-bar positive-edge flip-flop, sitting in the chip socket position on the checker board.
- Its inputs are the pins the checker drives; its outputs are the pins the checker reads.
- It lets the checker FSM be exercised on the FPGA without a physical part.
- Selectable fault modes force the checker down its failure path.

Parameters:
SYNC_STAGES, 2, synchronizer depth on every input pin (minimum 2)
OUT_DELAY, 0, extra registered cycles on the Q outputs, emulating propagation delay (0..15)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Pin1  input  1  flop 1 CLR_n
Pin2  input  1  flop 1 J
Pin4  input  1  flop 1 K_n
Pin5  input  1  flop 1 CLK
Pin13  input  1  flop 2 CLR_n
Pin12  input  1  flop 2 J
Pin10  input  1  flop 2 K_n
Pin9  input  1  flop 2 CLK
Pin3  output  1  flop 1 Q
Pin6  output  1  flop 1 Q_n
Pin11  output  1  flop 2 Q
Pin8  output  1  flop 2 Q_n
FaultSel  input  3  fault mode; 0 = healthy
ClearCnt  input  1  synchronous clear of EdgeCount
EdgeCount  output  8  saturating count of accepted rising edges, both flops combined

Behaviour:
- Reset low, asynchronous:
  - All synchronizer stages, edge-detect regs and delay pipeline go to 0.
  - Q1 = Q2 = 0, so Pin3 = Pin11 = 0 and Pin6 = Pin8 = 1.
  - EdgeCount = 0; registered FaultSel = 0.
- Reset release: synchronous; the first state update occurs on the first Clk edge after deassertion.
- Input path:
  - All eight pins pass through identical SYNC_STAGES flops, so relative J/K_n/CLK timing is preserved.
  - Each CLK pin also has a one-cycle history register. An edge is detected when prev = 0 and cur = 1.
- Per-flop next state, evaluated in priority order:
  - Synced CLR_n = 0: Q <= 0. Overrides any coincident edge; no edge is counted.
  - Otherwise, on an edge, using synced J/K_n from the same cycle:
    - J=0, K_n=0: Q <= 0
    - J=0, K_n=1: hold
    - J=1, K_n=0: toggle
    - J=1, K_n=1: Q <= 1
  - Otherwise hold.
- CLK held high does not re-trigger. A falling edge does nothing.
- Latency:
  - Pin change to output change = SYNC_STAGES + 1 + OUT_DELAY cycles (3 at defaults).
  - The CLR path has the same latency.
- Delay pipeline: OUT_DELAY = 0 means the state regs drive the outputs directly.
- Healthy outputs: Q_n is the complement of the delayed Q.
- FaultSel:
  - Registered once; it takes effect one cycle after change. A mid-operation change needs no flush.
  - 0: none
  - 1: Pin3 stuck 0
  - 2: Pin3 stuck 1
  - 3: Pin11 stuck 0
  - 4: Pin11 stuck 1
  - 5: Pin6 = Pin3 (complement broken)
  - 6: flop 1 treats toggle as hold. This is a state-level fault and persists in state after FaultSel returns to 0.
  - 7: flop 1 and flop 2 outputs swapped at the pins
- Modes 1–5 and 7 act only on the output mux; internal state stays correct.
- EdgeCount:
  - +1 per accepted edge; +2 when both flops accept in the same cycle.
  - Saturates at 255; 254 plus a double edge yields 255.
  - ClearCnt has priority over increment in the same cycle.

Decomposition:
- Shared package chip_emu_pkg holds:
  - fault_e enum for the eight FaultSel codes
  - JK-bar action typedef: CLR, HOLD, TOGGLE, SET, RESET
  - EDGE_CNT_MAX constant
- Sub-module jkbar_ff_core, instantiated twice:
  - inputs: synced CLR_n, J, K_n, CLK, toggle_inhibit
  - outputs: Q, edge_accepted
  - contains the edge-detect register and the state flop
- Top level holds the synchronizers, delay pipeline, fault mux and counter.

Test Plan:
- Reset low mid-run with Q1 = 1 → Pin3 = 0 and Pin6 = 1 immediately, EdgeCount = 0; after release, Q holds until an edge.
- Flop 1: CLR_n = 1, J = 1, K_n = 0, four rising edges on Pin5 → Pin3 sequence 1, 0, 1, 0, each change 3 cycles after its edge; EdgeCount = 4.
- Flop 2: J/K_n cycled through 00, 01, 11 with one edge each, starting from Q = 1 → Q2 sequence 0, 0, 1; Pin8 always equals ~Pin11.
- Pin1 held low during a Pin5 edge with J = 1, K_n = 1 → Pin3 stays 0; EdgeCount unchanged.
- FaultSel = 7 with Q1 = 1, Q2 = 0 → Pin3 = 0 and Pin11 = 1 one cycle later; FaultSel = 6 plus a toggle edge → Pin3 holds.
- EdgeCount preloaded to 254 by edges, then simultaneous Pin5 and Pin9 edges → 255; further edges keep 255; ClearCnt coincident with an edge → 0.

Source files
------------

// File: rtl/chip_74109_emulator_pkg.sv
// Shared types and constants for the 74109 socket emulator.
// Pure declarations: no latency and no backpressure.
package chip_emu_pkg;

  typedef enum logic [2:0] {
    FLT_NONE      = 3'd0,
    FLT_P3_SA0    = 3'd1,
    FLT_P3_SA1    = 3'd2,
    FLT_P11_SA0   = 3'd3,
    FLT_P11_SA1   = 3'd4,
    FLT_P6_EQ_P3  = 3'd5,
    FLT_NO_TOGGLE = 3'd6,
    FLT_SWAP      = 3'd7
  } fault_e;

  typedef enum logic [2:0] {
    ACT_CLR,
    ACT_HOLD,
    ACT_TOGGLE,
    ACT_SET,
    ACT_RESET
  } jk_action_e;

  localparam logic [7:0] EDGE_CNT_MAX = 8'd255;

  // CLR_n dominates; J/K_n only matter on an accepted rising edge.
  function automatic jk_action_e jk_decode(input logic clr_n, input logic edge_seen,
                                           input logic j, input logic k_n,
                                           input logic toggle_inhibit);
    jk_action_e act;
    act = ACT_HOLD;
    if (!clr_n) begin
      act = ACT_CLR;
    end else if (edge_seen) begin
      case ({j, k_n})
        2'b00:   act = ACT_RESET;
        2'b01:   act = ACT_HOLD;
        2'b10:   act = toggle_inhibit ? ACT_HOLD : ACT_TOGGLE;
        default: act = ACT_SET;
      endcase
    end
    return act;
  endfunction

endpackage

// File: rtl/chip_74109_emulator_if.sv
// Socket pin bundle between the board checker (master) and the emulated 74109 (slave).
// Wires only: no latency and no backpressure.
interface chip_74109_emulator_if;
  logic       Pin1;
  logic       Pin2;
  logic       Pin4;
  logic       Pin5;
  logic       Pin13;
  logic       Pin12;
  logic       Pin10;
  logic       Pin9;
  logic       Pin3;
  logic       Pin6;
  logic       Pin11;
  logic       Pin8;
  logic [2:0] FaultSel;
  logic       ClearCnt;
  logic [7:0] EdgeCount;

  modport master (
    output Pin1, Pin2, Pin4, Pin5, Pin13, Pin12, Pin10, Pin9, FaultSel, ClearCnt,
    input  Pin3, Pin6, Pin11, Pin8, EdgeCount
  );

  modport slave (
    input  Pin1, Pin2, Pin4, Pin5, Pin13, Pin12, Pin10, Pin9, FaultSel, ClearCnt,
    output Pin3, Pin6, Pin11, Pin8, EdgeCount
  );
endinterface

// File: rtl/chip_74109_emulator_ff_core.sv
// One JK-bar flop: rising-edge detect on the synced CLK pin plus the state flop.
// Q updates one cycle after the synced edge appears; no backpressure.
module jkbar_ff_core
  import chip_emu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_n_i,
  input  logic j_i,
  input  logic k_n_i,
  input  logic clk_pin_i,
  input  logic toggle_inhibit_i,
  output logic q_o,
  output logic edge_accepted_o
);

  logic       clk_prev_q;
  logic       q_q;
  logic       q_d;
  logic       edge_seen;
  jk_action_e act;

  assign edge_seen = clk_pin_i & ~clk_prev_q;

  always_comb begin
    act = jk_decode(clr_n_i, edge_seen, j_i, k_n_i, toggle_inhibit_i);
    q_d = q_q;
    case (act)
      ACT_CLR, ACT_RESET: q_d = 1'b0;
      ACT_TOGGLE:         q_d = ~q_q;
      ACT_SET:            q_d = 1'b1;
      default:            q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      clk_prev_q <= clk_pin_i;
      q_q        <= q_d;
    end
  end

  assign q_o             = q_q;
  // An edge masked by an active clear is not an accepted edge.
  assign edge_accepted_o = edge_seen & clr_n_i;

endmodule

// File: rtl/chip_74109_emulator.sv
// Behavioural 74109 (dual JK-bar flop) for the checker socket, with fault injection.
// Pin to output latency SYNC_STAGES + 1 + OUT_DELAY cycles; no backpressure.
module chip_74109_emulator
  import chip_emu_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OUT_DELAY   = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  chip_74109_emulator_if.slave  pins
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [7:0] pin_raw;
  logic [7:0] pin_sync;
  logic [7:0] sync_q [SYNC_N];
  fault_e     fault_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       q1;
  logic       q2;
  logic       acc1;
  logic       acc2;
  logic [1:0] q_now;
  logic [1:0] q_dly;
  logic [1:0] inc;
  logic [8:0] cnt_sum;
  logic       p3, p6, p11, p8;

  // Bit order: {CLK2, K_n2, J2, CLR_n2, CLK1, K_n1, J1, CLR_n1}.
  assign pin_raw = {pins.Pin9, pins.Pin10, pins.Pin12, pins.Pin13,
                    pins.Pin5, pins.Pin4, pins.Pin2, pins.Pin1};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_N; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_raw;
      for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pin_sync = sync_q[SYNC_N-1];

  jkbar_ff_core u_ff1 (
    .clk              (Clk),
    .rst_n            (Reset),
    .clr_n_i          (pin_sync[0]),
    .j_i              (pin_sync[1]),
    .k_n_i            (pin_sync[2]),
    .clk_pin_i        (pin_sync[3]),
    .toggle_inhibit_i (fault_q == FLT_NO_TOGGLE),
    .q_o              (q1),
    .edge_accepted_o  (acc1)
  );

  jkbar_ff_core u_ff2 (
    .clk              (Clk),
    .rst_n            (Reset),
    .clr_n_i          (pin_sync[4]),
    .j_i              (pin_sync[5]),
    .k_n_i            (pin_sync[6]),
    .clk_pin_i        (pin_sync[7]),
    .toggle_inhibit_i (1'b0),
    .q_o              (q2),
    .edge_accepted_o  (acc2)
  );

  assign q_now = {q2, q1};

  if (OUT_DELAY == 0) begin : g_no_dly
    assign q_dly = q_now;
  end else begin : g_dly
    logic [1:0] dly_q [OUT_DELAY];
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        for (int i = 0; i < OUT_DELAY; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= q_now;
        for (int i = 1; i < OUT_DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign q_dly = dly_q[OUT_DELAY-1];
  end

  always_comb begin
    inc     = {1'b0, acc1} + {1'b0, acc2};
    cnt_sum = {1'b0, cnt_q} + {7'b0, inc};
    cnt_d   = cnt_q;
    if (pins.ClearCnt) begin
      cnt_d = '0;
    end else if (cnt_sum > {1'b0, EDGE_CNT_MAX}) begin
      cnt_d = EDGE_CNT_MAX;
    end else begin
      cnt_d = cnt_sum[7:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      fault_q <= FLT_NONE;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_e'(pins.FaultSel);
    end
  end

  // Output-only faults touch nothing but this mux, so state stays correct.
  always_comb begin
    p3  = q_dly[0];
    p6  = ~q_dly[0];
    p11 = q_dly[1];
    p8  = ~q_dly[1];
    case (fault_q)
      FLT_P3_SA0:   p3  = 1'b0;
      FLT_P3_SA1:   p3  = 1'b1;
      FLT_P11_SA0:  p11 = 1'b0;
      FLT_P11_SA1:  p11 = 1'b1;
      FLT_P6_EQ_P3: p6  = q_dly[0];
      FLT_SWAP: begin
        p3  = q_dly[1];
        p6  = ~q_dly[1];
        p11 = q_dly[0];
        p8  = ~q_dly[0];
      end
      default: ;
    endcase
  end

  assign pins.Pin3      = p3;
  assign pins.Pin6      = p6;
  assign pins.Pin11     = p11;
  assign pins.Pin8      = p8;
  assign pins.EdgeCount = cnt_q;

endmodule

// File: tb/tb_chip_74109_emulator.sv
// Bench for chip_74109_emulator: directed socket scenarios plus random pin traffic
// checked every cycle against a cycle-history model of the part.
module tb_chip_74109_emulator;
  localparam int S  = 2;
  localparam int OD = 0;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  chip_74109_emulator_if bus ();

  chip_74109_emulator #(.SYNC_STAGES(S), .OUT_DELAY(OD)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .pins  (bus)
  );

  always #5 Clk = ~Clk;

  // Model: pin vectors seen at past clock edges, Q per flop, and Q history for output delay.
  logic [7:0] m_pq [$];
  logic [1:0] m_qd [$];
  logic       m_q1, m_q2;
  logic [2:0] m_fault;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pq.delete();
    for (int i = 0; i < S + 2; i++) m_pq.push_back(8'h00);
    m_qd.delete();
    for (int i = 0; i <= OD; i++) m_qd.push_back(2'b00);
    m_q1    = 1'b0;
    m_q2    = 1'b0;
    m_fault = 3'd0;
    m_cnt   = 0;
  endtask

  // 74109 truth table on an active edge.
  function automatic logic jk_next(input logic q, input logic j, input logic k_n, input logic inh);
    if (j)  return k_n ? 1'b1 : (inh ? q : !q);
    return k_n ? q : 1'b0;
  endfunction

  task automatic model_step();
    logic [7:0] now, cur, prev;
    int acc;
    logic inh;
    now = {bus.Pin9, bus.Pin10, bus.Pin12, bus.Pin13, bus.Pin5, bus.Pin4, bus.Pin2, bus.Pin1};
    m_pq.push_back(now);
    void'(m_pq.pop_front());
    prev = m_pq[0];
    cur  = m_pq[1];
    acc  = 0;
    inh  = (m_fault == 3'd6);
    if (!cur[0]) m_q1 = 1'b0;
    else if (cur[3] && !prev[3]) begin acc++; m_q1 = jk_next(m_q1, cur[1], cur[2], inh); end
    if (!cur[4]) m_q2 = 1'b0;
    else if (cur[7] && !prev[7]) begin acc++; m_q2 = jk_next(m_q2, cur[5], cur[6], 1'b0); end
    m_fault = bus.FaultSel;
    if (bus.ClearCnt) m_cnt = 0;
    else m_cnt = (m_cnt + acc > 255) ? 255 : m_cnt + acc;
    m_qd.push_back({m_q2, m_q1});
    void'(m_qd.pop_front());
  endtask

  task automatic compare_all();
    logic [1:0] qd;
    logic e3, e6, e11, e8;
    qd  = m_qd[0];
    e3  = qd[0];
    e6  = !qd[0];
    e11 = qd[1];
    e8  = !qd[1];
    case (m_fault)
      3'd1: e3  = 1'b0;
      3'd2: e3  = 1'b1;
      3'd3: e11 = 1'b0;
      3'd4: e11 = 1'b1;
      3'd5: e6  = qd[0];
      3'd7: begin e3 = qd[1]; e6 = !qd[1]; e11 = qd[0]; e8 = !qd[0]; end
      default: ;
    endcase
    chk("m_pin3", bus.Pin3, e3);
    chk("m_pin6", bus.Pin6, e6);
    chk("m_pin11", bus.Pin11, e11);
    chk("m_pin8", bus.Pin8, e8);
    chk("m_edgecount", bus.EdgeCount, m_cnt);
  endtask

  always @(posedge Clk) begin
    if (Reset === 1'b1) begin
      model_step();
      #1;
      compare_all();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called just after a negedge; finishes before the next posedge.
  task automatic do_reset();
    #2 Reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pin3", bus.Pin3, 1'b0);
    chk("rst_pin6", bus.Pin6, 1'b1);
    chk("rst_pin11", bus.Pin11, 1'b0);
    chk("rst_pin8", bus.Pin8, 1'b1);
    chk("rst_cnt", bus.EdgeCount, 0);
    #1 Reset = 1'b1;
  endtask

  task automatic edge5(input logic j, input logic kn, input logic expq, input string nm);
    logic expn;
    expn = !expq;
    bus.Pin2 = j; bus.Pin4 = kn; bus.Pin5 = 1'b1;
    tick(3);
    chk(nm, bus.Pin3, expq);
    chk({nm, "_n"}, bus.Pin6, expn);
    bus.Pin5 = 1'b0;
    tick(2);
  endtask

  task automatic edge9(input logic j, input logic kn, input logic expq, input string nm);
    logic expn;
    expn = !expq;
    bus.Pin12 = j; bus.Pin10 = kn; bus.Pin9 = 1'b1;
    tick(3);
    chk(nm, bus.Pin11, expq);
    chk({nm, "_n"}, bus.Pin8, expn);
    bus.Pin9 = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [3:0] seq;
    logic       early;
    Reset = 1'b0;
    model_reset();
    bus.Pin1 = 1'b1; bus.Pin2 = 1'b1; bus.Pin4 = 1'b0; bus.Pin5 = 1'b0;
    bus.Pin13 = 1'b1; bus.Pin12 = 1'b0; bus.Pin10 = 1'b1; bus.Pin9 = 1'b0;
    bus.FaultSel = 3'd0; bus.ClearCnt = 1'b0;
    tick(1);
    do_reset();
    tick(4);

    // Flop 1 toggling: Pin3 goes 1,0,1,0, each change on the third cycle after the edge.
    seq = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      early = !seq[i];
      bus.Pin5 = 1'b1;
      tick(2);
      chk("tog_early", bus.Pin3, early);
      tick(1);
      chk("tog_q", bus.Pin3, seq[i]);
      bus.Pin5 = 1'b0;
      tick(2);
    end
    chk("tog_cnt", bus.EdgeCount, 4);

    // Flop 2: set, then 00 -> 0, 01 -> 0, 11 -> 1.
    edge9(1'b1, 1'b1, 1'b1, "f2_set");
    edge9(1'b0, 1'b0, 1'b0, "f2_jk00");
    edge9(1'b0, 1'b1, 1'b0, "f2_jk01");
    edge9(1'b1, 1'b1, 1'b1, "f2_jk11");
    chk("f2_cnt", bus.EdgeCount, 8);

    // Clear held low across an edge with J=1,K_n=1.
    bus.Pin1 = 1'b0; bus.Pin2 = 1'b1; bus.Pin4 = 1'b1; bus.Pin5 = 1'b1;
    tick(4);
    chk("clr_q", bus.Pin3, 1'b0);
    chk("clr_cnt", bus.EdgeCount, 8);
    bus.Pin5 = 1'b0; bus.Pin1 = 1'b1;
    tick(3);

    // Swap fault with Q1=1, Q2=0.
    edge5(1'b1, 1'b1, 1'b1, "pre7_q1");
    edge9(1'b0, 1'b0, 1'b0, "pre7_q2");
    bus.FaultSel = 3'd7;
    tick(1);
    chk("swap_pin3", bus.Pin3, 1'b0);
    chk("swap_pin11", bus.Pin11, 1'b1);
    chk("swap_pin6", bus.Pin6, 1'b1);
    chk("swap_pin8", bus.Pin8, 1'b0);
    bus.FaultSel = 3'd0;
    tick(1);
    chk("unswap_pin3", bus.Pin3, 1'b1);

    // Toggle-inhibit fault: a toggle edge holds, and the held state persists.
    bus.FaultSel = 3'd6;
    edge5(1'b1, 1'b0, 1'b1, "f6_hold");
    bus.FaultSel = 3'd0;
    tick(2);
    chk("f6_persist", bus.Pin3, 1'b1);
    chk("f6_cnt", bus.EdgeCount, 11);

    // Mid-run reset with Q1=1, then Q holds until the next edge.
    do_reset();
    tick(5);
    chk("post_rst_hold", bus.Pin3, 1'b0);
    edge5(1'b1, 1'b0, 1'b1, "post_rst_tog");
    chk("post_rst_cnt", bus.EdgeCount, 1);

    // Saturation: 253 more edges to 254, then a double edge to 255.
    bus.Pin2 = 1'b0; bus.Pin4 = 1'b1;
    for (int i = 0; i < 253; i++) begin
      bus.Pin5 = 1'b1; tick(1);
      bus.Pin5 = 1'b0; tick(1);
    end
    tick(3);
    chk("sat_254", bus.EdgeCount, 254);
    bus.Pin5 = 1'b1; bus.Pin9 = 1'b1;
    tick(3);
    chk("sat_double", bus.EdgeCount, 255);
    bus.Pin5 = 1'b0; bus.Pin9 = 1'b0;
    tick(2);
    bus.Pin5 = 1'b1; tick(1); bus.Pin5 = 1'b0;
    tick(4);
    chk("sat_hold", bus.EdgeCount, 255);
    bus.Pin5 = 1'b1;
    tick(2);
    bus.ClearCnt = 1'b1;
    tick(1);
    bus.ClearCnt = 1'b0;
    chk("clr_wins", bus.EdgeCount, 0);
    bus.Pin5 = 1'b0;
    tick(3);
    chk("clr_after", bus.EdgeCount, 0);

    // Random pin traffic, fault modes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      bus.Pin1  = ($urandom_range(0, 15) != 0);
      bus.Pin13 = ($urandom_range(0, 15) != 0);
      bus.Pin2  = 1'($urandom);
      bus.Pin4  = 1'($urandom);
      bus.Pin5  = 1'($urandom);
      bus.Pin12 = 1'($urandom);
      bus.Pin10 = 1'($urandom);
      bus.Pin9  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) bus.FaultSel = 3'($urandom);
      bus.ClearCnt = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
